// File: rtl/controler_pkg.sv
// Shared encodings and default tuning values for the line-following direction controller.
package controler_pkg;

  typedef enum logic [2:0] {
    OPRIT   = 3'd0,
    INAINTE = 3'd1,
    STANGA  = 3'd2,
    DREAPTA = 3'd3,
    CAUTARE = 3'd4,
    PIERDUT = 3'd5
  } stare_t;

  typedef enum logic {
    LAT_STANGA  = 1'b0,
    LAT_DREAPTA = 1'b1
  } latura_t;

  localparam int DIV_TICK_DEF  = 50000;
  localparam int DEBOUNCE_DEF  = 4;
  localparam int RAMP_STEP_DEF = 25;
  localparam int V_MAX_DEF     = 900;
  localparam int V_TURN_DEF    = 400;
  localparam int V_SEARCH_DEF  = 300;
  localparam int T_LOST_DEF    = 500;

  // Sensor pattern [left,centre,right] to steering state; 101 keeps the caller's hold state.
  function automatic stare_t map_pattern(input logic [2:0] p, input stare_t hold);
    case (p)
      3'b010, 3'b111: return INAINTE;
      3'b100, 3'b110: return STANGA;
      3'b001, 3'b011: return DREAPTA;
      3'b000:         return CAUTARE;
      default:        return hold;
    endcase
  endfunction

endpackage

// File: rtl/controler_directie_bin_la_bcd.sv
// Combinational 10-bit binary to 3-digit BCD converter (shift-add-3).
module bin_la_bcd (
  input  logic [9:0]  i_bin,
  output logic [11:0] o_bcd
);

  logic [21:0] w_sh;

  always_comb begin
    w_sh = {12'd0, i_bin};
    for (int i = 0; i < 10; i++) begin
      if (w_sh[13:10] >= 4'd5) w_sh[13:10] = w_sh[13:10] + 4'd3;
      if (w_sh[17:14] >= 4'd5) w_sh[17:14] = w_sh[17:14] + 4'd3;
      if (w_sh[21:18] >= 4'd5) w_sh[21:18] = w_sh[21:18] + 4'd3;
      w_sh = w_sh << 1;
    end
  end

  assign o_bcd = w_sh[21:10];

endmodule

// File: rtl/controler_directie.sv
// Line-following direction controller: tick divider, sensor sync/debounce,
// steering FSM, slew-limited duty ramps and BCD duty outputs for the PWM generator.
module controler_directie
  import controler_pkg::*;
#(
  parameter int DIV_TICK  = DIV_TICK_DEF,
  parameter int DEBOUNCE  = DEBOUNCE_DEF,
  parameter int RAMP_STEP = RAMP_STEP_DEF,
  parameter int V_MAX     = V_MAX_DEF,
  parameter int V_TURN    = V_TURN_DEF,
  parameter int V_SEARCH  = V_SEARCH_DEF,
  parameter int T_LOST    = T_LOST_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  senzori,
  output logic [11:0] factor_PWM_A,
  output logic [11:0] factor_PWM_B,
  output logic        activ,
  output logic [2:0]  stare
);

  localparam int TW = (DIV_TICK > 1) ? $clog2(DIV_TICK) : 1;
  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int LW = (T_LOST > 1)   ? $clog2(T_LOST)   : 1;

  logic [TW-1:0] r_tick_cnt;
  logic          w_tick;

  logic [2:0]    r_sync1, r_sync2, r_esant, r_filtrat;
  logic [DW-1:0] r_stabil;

  stare_t        r_stare;
  stare_t        w_map;
  latura_t       r_latura;
  logic [LW-1:0] r_lost;

  logic [9:0]    r_cur_a, r_cur_b;
  logic [9:0]    w_tinta_a, w_tinta_b;
  logic [11:0]   w_bcd_a, w_bcd_b;
  logic [11:0]   r_pwm_a, r_pwm_b;
  logic          r_activ;
  logic          w_ruleaza;

  function automatic logic [9:0] rampa(input logic [9:0] cur, input logic [9:0] tinta);
    logic [10:0] sus, prag;
    sus  = {1'b0, cur}   + 11'(RAMP_STEP);
    prag = {1'b0, tinta} + 11'(RAMP_STEP);
    if (cur < tinta)      return (sus > {1'b0, tinta}) ? tinta : sus[9:0];
    else if (cur > tinta) return ({1'b0, cur} < prag) ? tinta : cur - 10'(RAMP_STEP);
    else                  return cur;
  endfunction

  assign w_tick = (r_tick_cnt == TW'(DIV_TICK - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + TW'(1);
  end

  // A pattern is accepted once it has matched the stored sample on DEBOUNCE consecutive ticks.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_esant   <= '0;
      r_stabil  <= '0;
      r_filtrat <= '0;
    end else begin
      r_sync1 <= senzori;
      r_sync2 <= r_sync1;
      if (w_tick) begin
        if (r_sync2 == r_esant) begin
          if (r_stabil != DW'(DEBOUNCE - 1)) r_stabil <= r_stabil + DW'(1);
        end else begin
          r_stabil <= '0;
          r_esant  <= r_sync2;
        end
      end
      if (r_stabil == DW'(DEBOUNCE - 1)) r_filtrat <= r_esant;
    end
  end

  assign w_map = map_pattern(r_filtrat, (r_stare == OPRIT) ? INAINTE : r_stare);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stare  <= OPRIT;
      r_latura <= LAT_STANGA;
      r_lost   <= '0;
    end else if (w_tick) begin
      if (!start) begin
        r_stare <= OPRIT;
        r_lost  <= '0;
      end else if (r_stare != PIERDUT) begin
        if (r_stare == CAUTARE && w_map == CAUTARE) begin
          if (r_lost == LW'(T_LOST - 1)) begin
            r_stare <= PIERDUT;
            r_lost  <= '0;
          end else begin
            r_lost <= r_lost + LW'(1);
          end
        end else begin
          r_stare <= w_map;
          r_lost  <= '0;
        end
        if (w_map == STANGA)       r_latura <= LAT_STANGA;
        else if (w_map == DREAPTA) r_latura <= LAT_DREAPTA;
      end
    end
  end

  always_comb begin
    w_tinta_a = '0;
    w_tinta_b = '0;
    case (r_stare)
      INAINTE: begin w_tinta_a = 10'(V_MAX);  w_tinta_b = 10'(V_MAX);  end
      STANGA:  begin w_tinta_a = 10'(V_TURN); w_tinta_b = 10'(V_MAX);  end
      DREAPTA: begin w_tinta_a = 10'(V_MAX);  w_tinta_b = 10'(V_TURN); end
      CAUTARE: begin
        if (r_latura == LAT_STANGA) w_tinta_b = 10'(V_SEARCH);
        else                        w_tinta_a = 10'(V_SEARCH);
      end
      default: ;
    endcase
  end

  // Ramp follows the registered state, so it lags a state change by one tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cur_a <= '0;
      r_cur_b <= '0;
    end else if (w_tick) begin
      r_cur_a <= rampa(r_cur_a, w_tinta_a);
      r_cur_b <= rampa(r_cur_b, w_tinta_b);
    end
  end

  bin_la_bcd u_bcd_a (.i_bin(r_cur_a), .o_bcd(w_bcd_a));
  bin_la_bcd u_bcd_b (.i_bin(r_cur_b), .o_bcd(w_bcd_b));

  assign w_ruleaza = (r_stare == INAINTE) || (r_stare == STANGA) ||
                     (r_stare == DREAPTA) || (r_stare == CAUTARE);

  // Enable stays up in OPRIT/PIERDUT until both channels have coasted to zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pwm_a <= '0;
      r_pwm_b <= '0;
      r_activ <= 1'b0;
    end else begin
      r_pwm_a <= w_bcd_a;
      r_pwm_b <= w_bcd_b;
      r_activ <= w_ruleaza || (r_cur_a != '0) || (r_cur_b != '0);
    end
  end

  assign factor_PWM_A = r_pwm_a;
  assign factor_PWM_B = r_pwm_b;
  assign activ        = r_activ;
  assign stare        = r_stare;

endmodule
